vram_screen_ops: RTL and testbench
==================================

// Module: vram_screen_ops
// PURPOSE
//  Owns the single video-RAM port shared by the text editor and a bulk screen-operation engine.
//  Idle: editor bus passes straight to VRAM. On a command it runs clear / row-fill / scroll,
//  holding the editor off until the operation completes.
//  Sits between the editor/command source and the 16-bit character VRAM (word = [14]cursor,[13]blink,[12]inv,[11:8]RGBI,[7:0]char).
// PARAMETERS
//  COLS       40        characters per row
//  ROWS       28        rows per screen (COLS*ROWS = 1120 words)
//  AW         11        VRAM address width
//  FILL_WORD  16'h0F00  word written by clear/fill (white, NUL char, cursor bit 0)
// PORTS
//  sys_clk    in   1   clock, all logic on rising edge
//  sys_rst    in   1   synchronous reset, active high
//  ed_addr    in   AW  editor VRAM address
//  ed_data    in   16  editor write data
//  ed_we      in   1   editor write enable
//  ed_active  in   1   editor mid-sequence (not waiting for a key); blocks command acceptance
//  ed_hold    out  1   editor must not start a new key sequence while 1
//  cmd_valid  in   1   command request
//  cmd_op     in   2   00 clear screen, 01 fill row, 10 scroll up, 11 scroll down (optional)
//  cmd_row    in   5   row index for fill-row
//  cmd_ready  out  1   command accepted on cycle with cmd_valid & cmd_ready
//  done       out  1   one-cycle pulse at operation end
//  err        out  1   valid with done: illegal op/row, no VRAM writes made
//  mem_addr   out  AW  VRAM address
//  mem_data   out  16  VRAM write data
//  mem_we     out  1   VRAM write enable
//  mem_rdata  in   16  VRAM read data, valid one cycle after mem_addr presented
// BEHAVIOUR
//  - Reset: state IDLE, done=0, err=0, ed_hold=0, counters 0; mem_we forced 0 while sys_rst=1.
//  - cmd_ready = (state==IDLE) & ~ed_active. ed_hold = (state!=IDLE).
//  - IDLE: mem_addr/mem_data/mem_we = ed_addr/ed_data/ed_we (combinational mux, zero latency).
//  - Accept at edge N: cmd_op/cmd_row latched; first engine VRAM access in cycle N+1; editor bus ignored until IDLE.
//  - States: IDLE -> FILL (clear, fill row) | CPY_RD -> CPY_WR loop -> FILL (scroll) -> DONE -> IDLE.
//  - FILL: one write/cycle, mem_data=FILL_WORD, addr ascending. Clear: 0..COLS*ROWS-1.
//    Fill row r: r*COLS .. r*COLS+COLS-1.
//  - Scroll up: for d=0..(ROWS-1)*COLS-1: CPY_RD addr=d+COLS we=0; CPY_WR addr=d,
//    data=mem_rdata & 16'hBFFF (cursor cleared), we=1. Then FILL last row. 2 cycles/copied word.
//  - DONE: done=1 one cycle, mem_we=0, then IDLE (cmd_ready may rise next cycle).
//  - Cycle counts accept->done (exclusive): clear 1120+1, fill row 40+1, scroll 2*1080+40+1 (defaults).
//  - Illegal: cmd_row>=ROWS on fill row, or op 11 without macro -> straight to DONE, err=1, no writes.
//  - err=0 whenever done=0.
//  - cmd_valid while ed_active or busy: not accepted, request must be held; no queueing.
//  - Address counters never exceed COLS*ROWS-1; no wrap-around write.
//  - sys_rst mid-operation: abort at that edge, IDLE, no further writes, no done pulse; VRAM left partially updated.
// CONFIGURATION
//  - SCREEN_OPS_SCROLL_DN_EN defined: op 11 = scroll down: copy descending,
//    d=COLS*ROWS-1 downto COLS, src d-COLS, cursor bit cleared; then fill row 0. Same cycle cost as scroll up.
//  - Undefined: op 11 is illegal (done+err, no writes); no descending-copy logic synthesised.
// TESTING
//  1. Reset, cmd clear -> 1120 writes of 16'h0F00 to addr 0..1119 in order, done+err=0 at cycle 1121 after accept.
//  2. Preload mem[i]=16'h4000|i, scroll up -> mem[i]=i+40 (bit14 clear) for i<1080,
//     mem[1080..1119]=16'h0F00, done at cycle 2201.
//  3. Fill row 27 -> writes only 1080..1119; fill row 28 -> done with err=1 next cycle, zero writes.
//  4. ed_active=1 with cmd_valid=1 -> cmd_ready=0, editor writes pass through unchanged; drop ed_active -> accepted.
//  5. sys_rst asserted mid-scroll (d=500) -> mem_we=0 from that edge, no done, IDLE, ed_hold=0.
//  6. Op 11 with SCREEN_OPS_SCROLL_DN_EN -> mem[i]=old mem[i-40] for i>=40, row 0 = 16'h0F00;
//     without macro -> err=1, no writes.

Source files
------------

// File: rtl/vram_screen_ops.sv
// VRAM port owner: passes the editor bus through when idle, otherwise runs clear/fill/scroll.
// Optional scroll-down (op 11) is built only when SCREEN_OPS_SCROLL_DN_EN is defined.
module vram_screen_ops #(
  parameter int unsigned COLS      = 40,
  parameter int unsigned ROWS      = 28,
  parameter int unsigned AW        = 11,
  parameter logic [15:0] FILL_WORD = 16'h0F00
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [AW-1:0] ed_addr,
  input  logic [15:0]   ed_data,
  input  logic          ed_we,
  input  logic          ed_active,
  output logic          ed_hold,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [4:0]    cmd_row,
  output logic          cmd_ready,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_data,
  output logic          mem_we,
  input  logic [15:0]   mem_rdata
);

  localparam logic [AW-1:0] ONE_A       = AW'(1);
  localparam logic [AW-1:0] COLS_A      = AW'(COLS);
  localparam logic [AW-1:0] LAST_A      = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LROW_A      = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] CPY_END_UP  = AW'((ROWS - 1) * COLS - 1);
  localparam logic [15:0]   CURSOR_CLR  = 16'hBFFF;

  typedef enum logic [2:0] {IDLE, FILL, CPY_RD, CPY_WR, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] fill_end, fill_end_nxt;
  logic          err_q, err_nxt;
  logic          accept;
`ifdef SCREEN_OPS_SCROLL_DN_EN
  logic          dn_q, dn_nxt;
`endif

  assign cmd_ready = (state == IDLE) && !ed_active;
  assign accept    = cmd_valid && cmd_ready;
  assign ed_hold   = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = done && err_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_end <= '0;
      err_q    <= 1'b0;
`ifdef SCREEN_OPS_SCROLL_DN_EN
      dn_q     <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      fill_end <= fill_end_nxt;
      err_q    <= err_nxt;
`ifdef SCREEN_OPS_SCROLL_DN_EN
      dn_q     <= dn_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    fill_end_nxt = fill_end;
    err_nxt      = err_q;
`ifdef SCREEN_OPS_SCROLL_DN_EN
    dn_nxt       = dn_q;
`endif
    mem_addr     = ed_addr;
    mem_data     = ed_data;
    mem_we       = ed_we;
    case (state)
      IDLE: begin
        if (accept) begin
          err_nxt = 1'b0;
          case (cmd_op)
            2'b00: begin
              state_nxt    = FILL;
              cnt_nxt      = '0;
              fill_end_nxt = LAST_A;
            end
            2'b01: begin
              if (32'(cmd_row) < ROWS) begin
                state_nxt    = FILL;
                cnt_nxt      = AW'(cmd_row) * COLS_A;
                fill_end_nxt = AW'(cmd_row) * COLS_A + COLS_A - ONE_A;
              end else begin
                state_nxt = DONE;
                err_nxt   = 1'b1;
              end
            end
            2'b10: begin
              state_nxt = CPY_RD;
              cnt_nxt   = '0;
`ifdef SCREEN_OPS_SCROLL_DN_EN
              dn_nxt    = 1'b0;
`endif
            end
            default: begin
`ifdef SCREEN_OPS_SCROLL_DN_EN
              state_nxt = CPY_RD;
              cnt_nxt   = LAST_A;
              dn_nxt    = 1'b1;
`else
              state_nxt = DONE;
              err_nxt   = 1'b1;
`endif
            end
          endcase
        end
      end
      FILL: begin
        mem_addr = cnt;
        mem_data = FILL_WORD;
        mem_we   = 1'b1;
        if (cnt == fill_end) state_nxt = DONE;
        else                 cnt_nxt   = cnt + ONE_A;
      end
      CPY_RD: begin
        // cnt holds the destination; the source row sits one row away
`ifdef SCREEN_OPS_SCROLL_DN_EN
        mem_addr = dn_q ? (cnt - COLS_A) : (cnt + COLS_A);
`else
        mem_addr = cnt + COLS_A;
`endif
        mem_data  = '0;
        mem_we    = 1'b0;
        state_nxt = CPY_WR;
      end
      CPY_WR: begin
        mem_addr  = cnt;
        mem_data  = mem_rdata & CURSOR_CLR;
        mem_we    = 1'b1;
        state_nxt = CPY_RD;
`ifdef SCREEN_OPS_SCROLL_DN_EN
        if (dn_q) begin
          if (cnt == COLS_A) begin
            state_nxt    = FILL;
            cnt_nxt      = '0;
            fill_end_nxt = COLS_A - ONE_A;
          end else begin
            cnt_nxt = cnt - ONE_A;
          end
        end else
`endif
        if (cnt == CPY_END_UP) begin
          state_nxt    = FILL;
          cnt_nxt      = LROW_A;
          fill_end_nxt = LAST_A;
        end else begin
          cnt_nxt = cnt + ONE_A;
        end
      end
      DONE: begin
        mem_addr  = cnt;
        mem_data  = '0;
        mem_we    = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        mem_we    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    if (sys_rst) mem_we = 1'b0;
  end

endmodule

// File: tb/tb_vram_screen_ops.sv
// Bench for vram_screen_ops: owns a VRAM model, predicts every write and the done cycle.
module tb_vram_screen_ops;
  localparam int unsigned COLS  = 40;
  localparam int unsigned ROWS  = 28;
  localparam int unsigned TOTAL = 1120;
  localparam int unsigned AW    = 11;
  localparam logic [15:0] FILLW = 16'h0F00;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [AW-1:0] ed_addr = '0;
  logic [15:0]   ed_data = '0;
  logic          ed_we = 1'b0, ed_active = 1'b0, ed_hold;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [4:0]    cmd_row = '0;
  logic          cmd_ready, done, err;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data, mem_rdata;
  logic          mem_we;

  vram_screen_ops #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .FILL_WORD(FILLW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ed_addr(ed_addr), .ed_data(ed_data),
    .ed_we(ed_we), .ed_active(ed_active), .ed_hold(ed_hold), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_ready(cmd_ready), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  logic [15:0] vram [0:2047];
  logic [15:0] ref_mem [0:TOTAL-1];
  logic        preload = 1'b0;

  always @(posedge sys_clk) begin
    if (preload) begin
      for (int i = 0; i < TOTAL; i++) vram[i] <= 16'h4000 | 16'(i);
    end else if (mem_we) begin
      vram[mem_addr] <= mem_data;
    end
    mem_rdata <= vram[mem_addr];
  end

  typedef struct packed { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
  wr_t expq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    end else if (mem_we) begin
      if (expq.size() == 0) begin
        chk("unexpected_write_addr", {21'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("wr_addr", {21'd0, mem_addr}, {21'd0, e.addr});
        chk("wr_data", {16'd0, mem_data}, {16'd0, e.data});
      end
    end
    if (!done) chk("err_without_done", {31'd0, err}, 32'd0);
  end

  task automatic push_wr(input int a, input logic [15:0] d);
    expq.push_back({11'(a), d});
    ref_mem[a] = d;
  endtask

  // Screen-level model: which words each operation writes, in order, and with what.
  task automatic build_exp(input logic [1:0] op, input logic [4:0] row, input int maxw,
                           output bit illegal);
    logic [15:0] snap [0:TOTAL-1];
    wr_t seq[$];
    snap = ref_mem;
    illegal = 1'b0;
    case (op)
      2'b00: for (int i = 0; i < TOTAL; i++) seq.push_back({11'(i), FILLW});
      2'b01: begin
        if (int'(row) < ROWS) begin
          for (int i = 0; i < COLS; i++) seq.push_back({11'(int'(row) * COLS + i), FILLW});
        end else illegal = 1'b1;
      end
      2'b10: begin
        for (int i = 0; i < TOTAL - COLS; i++) seq.push_back({11'(i), snap[i + COLS] & 16'hBFFF});
        for (int i = TOTAL - COLS; i < TOTAL; i++) seq.push_back({11'(i), FILLW});
      end
      default: begin
`ifdef SCREEN_OPS_SCROLL_DN_EN
        for (int i = TOTAL - 1; i >= COLS; i--) seq.push_back({11'(i), snap[i - COLS] & 16'hBFFF});
        for (int i = 0; i < COLS; i++) seq.push_back({11'(i), FILLW});
`else
        illegal = 1'b1;
`endif
      end
    endcase
    for (int i = 0; i < seq.size() && i < maxw; i++) push_wr(int'(seq[i].addr), seq[i].data);
  endtask

  task automatic wait_accept(input string tag);
    bit acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (cmd_ready) begin acc = 1'b1; break; end
    end
    chk({tag, "_accept"}, {31'd0, acc}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] row,
                        input int exp_cyc, input bit ed_noise);
    bit illegal;
    int got = 0;
    @(posedge sys_clk); #1;
    build_exp(op, row, 1 << 30, illegal);
    cmd_op = op; cmd_row = row; cmd_valid = 1'b1;
    wait_accept(tag);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    if (ed_noise) begin ed_addr = 11'd5; ed_data = 16'hDEAD; ed_we = 1'b1; end
    for (int k = 1; k <= exp_cyc + 8; k++) begin
      @(negedge sys_clk);
      if (done) begin got = k; break; end
      chk({tag, "_busy"}, {30'd0, ed_hold, cmd_ready}, 32'd2);
    end
    chk({tag, "_done_cycle"}, got, exp_cyc);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, illegal});
    ed_we = 1'b0;
    chk({tag, "_leftover"}, expq.size(), 32'd0);
    @(posedge sys_clk); #1;
    chk({tag, "_idle"}, {29'd0, ed_hold, cmd_ready, done}, 32'd2);
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    int first = 0;
    for (int i = TOTAL - 1; i >= 0; i--)
      if (vram[i] !== ref_mem[i]) begin bad++; first = i; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_mem words_wrong=%0d first_addr=%0d act=%0h exp=%0h",
               tag, bad, first, vram[first], ref_mem[first]);
    end
  endtask

  task automatic do_preload();
    @(posedge sys_clk); #1;
    preload = 1'b1;
    @(posedge sys_clk); #1;
    preload = 1'b0;
    for (int i = 0; i < TOTAL; i++) ref_mem[i] = 16'h4000 | 16'(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ill;
    // reset: editor write attempts must not reach VRAM
    ed_we = 1'b1; ed_addr = 11'd3; ed_data = 16'h1111;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_outputs", {28'd0, mem_we, done, err, ed_hold}, 32'd0);
    @(posedge sys_clk); #1;
    ed_we = 1'b0; sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("post_rst_ready", {30'd0, cmd_ready, ed_hold}, 32'd2);

    run_op("clear", 2'b00, 5'd0, 1121, 1'b1);
    check_mem("clear");
    chk("clear_pin0", {16'd0, vram[0]}, 32'h0F00);
    chk("clear_pin1119", {16'd0, vram[1119]}, 32'h0F00);

    do_preload();
    run_op("scroll_up", 2'b10, 5'd0, 2201, 1'b0);
    check_mem("scroll_up");
    chk("up_pin0", {16'd0, vram[0]}, 32'h0028);
    chk("up_pin1079", {16'd0, vram[1079]}, 32'h045F);
    chk("up_pin1080", {16'd0, vram[1080]}, 32'h0F00);

    run_op("fill27", 2'b01, 5'd27, 41, 1'b0);
    run_op("fill28", 2'b01, 5'd28, 1, 1'b0);
    check_mem("fill");

    // editor owns the bus while mid-sequence; command waits
    @(posedge sys_clk); #1;
    ed_active = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_row = 5'd3;
    for (int k = 0; k < 3; k++) begin
      push_wr(100 + k, 16'h1234 + 16'(k));
      ed_addr = 11'(100 + k); ed_data = 16'h1234 + 16'(k); ed_we = 1'b1;
      @(negedge sys_clk);
      chk("edact_ready_hold", {30'd0, cmd_ready, ed_hold}, 32'd0);
      @(posedge sys_clk); #1;
    end
    ed_we = 1'b0; cmd_valid = 1'b0; ed_active = 1'b0;
    run_op("fill3", 2'b01, 5'd3, 41, 1'b0);
    check_mem("editor");
    chk("ed_pin101", {16'd0, vram[101]}, 32'h1235);

    // reset in the middle of a scroll, while reading source for d=500
    do_preload();
    build_exp(2'b10, 5'd0, 500, ill);
    cmd_op = 2'b10; cmd_valid = 1'b1;
    wait_accept("abort");
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    repeat (1000) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_we_done", {30'd0, mem_we, done}, 32'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      chk("abort_idle", {29'd0, done, ed_hold, cmd_ready}, 32'd1);
    end
    chk("abort_leftover", expq.size(), 32'd0);
    check_mem("abort");
    chk("abort_pin499", {16'd0, vram[499]}, 32'h021B);
    chk("abort_pin500", {16'd0, vram[500]}, 32'h41F4);

    do_preload();
`ifdef SCREEN_OPS_SCROLL_DN_EN
    run_op("op11", 2'b11, 5'd0, 2201, 1'b0);
    check_mem("op11");
    chk("dn_pin0", {16'd0, vram[0]}, 32'h0F00);
    chk("dn_pin40", {16'd0, vram[40]}, 32'h0000);
    chk("dn_pin1119", {16'd0, vram[1119]}, 32'h0437);
`else
    run_op("op11", 2'b11, 5'd0, 1, 1'b0);
    check_mem("op11");
    chk("op11_pin40", {16'd0, vram[40]}, 32'h4028);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
